// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the MARS memory-mapped UART transmitter:
// FSM encoding, register map and CTRL bit positions.
package mmio_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Register offsets from the control register address.
   localparam logic [31:0] CTRL_OFS = 32'd0;
   localparam logic [31:0] DATA_OFS = 32'd4;

   // MARS transmitter control register address.
   localparam logic [31:0] MARS_MMIO_TX_BASE = 32'hFFFF_0008;

   // CTRL register bit positions.
   localparam int READY = 0;
   localparam int IE    = 1;
   localparam int OVR   = 2;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output.
// A push while full is dropped even if a pop happens on the same edge.
// DEPTH must be a power of 2 and at least 2.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk_in,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array write port.
   always_ff @(posedge clk_in) begin
      // NOTE: storage is not reset; empty/count guard against reading stale entries.
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// MARS memory-mapped UART transmitter: CTRL/DATA registers on the CPU
// data bus, a byte FIFO, and an 8N1 serializer driving a registered tx.
module mmio_uart_tx #(
   parameter int          CLK_DIV    = 100,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] ADDR_BASE  = mmio_uart_pkg::MARS_MMIO_TX_BASE
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        ram_ena,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_wdata,
   output logic [31:0] ram_rdata,
   output logic        sel,
   output logic        tx,
   output logic        busy,
   output logic        tx_irq
);
   import mmio_uart_pkg::*;

   localparam int             BW       = $clog2(CLK_DIV);
   localparam logic [BW-1:0]  BIT_LAST = BW'(CLK_DIV - 1);
   localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

   // Register interface.
   logic [31:0]   reg_ofs;
   logic          wr_ctrl;
   logic          wr_data;
   logic          ready;
   logic          ie;
   logic          ovr;
   logic [7:0]    last_byte;

   // FIFO interface.
   logic          fifo_push;
   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

   // Serializer state.
   tx_state_t     state, state_n;
   logic [BW-1:0] bcnt, bcnt_n;
   logic [2:0]    bitidx, bitidx_n;
   logic [7:0]    shreg, shreg_n;
   logic          tx_d;
   logic          bit_end;

   // Byte lanes and sub-word address bits the register map ignores.
   logic          unused_bits;
   assign unused_bits = ^{ram_addr[1:0], ram_wdata[31:8]};

   assign sel       = (ram_addr[31:3] == ADDR_BASE[31:3]);
   assign reg_ofs   = {29'b0, ram_addr[2], 2'b00};
   assign wr_ctrl   = sel & ram_ena & (reg_ofs == CTRL_OFS);
   assign wr_data   = sel & ram_ena & (reg_ofs == DATA_OFS);
   assign ready     = (fifo_count < FULL_CNT);
   assign fifo_push = wr_data & ~fifo_full;
   assign bit_end   = (bcnt == BIT_LAST);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in (clk_in),
      .reset  (reset),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .din    (ram_wdata[7:0]),
      .dout   (fifo_dout),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // CPU-visible control/status state: interrupt enable, overrun flag, last byte.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         ie        <= 1'b0;
         ovr       <= 1'b0;
         last_byte <= 8'h00;
      end else begin
         if (wr_ctrl) begin
            ie <= ram_wdata[IE];
            if (ram_wdata[OVR]) ovr <= 1'b0;
         end
         if (wr_data) begin
            if (fifo_full) ovr       <= 1'b1;
            else           last_byte <= ram_wdata[7:0];
         end
      end
   end

   // Read mux; side-effect free and zero when the block is not addressed.
   always_comb begin
      // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
      ram_rdata = 32'h0;
      if (sel) begin
         if (reg_ofs == DATA_OFS) begin
            ram_rdata = {24'h0, last_byte};
         end else begin
            ram_rdata[READY] = ready;
            ram_rdata[IE]    = ie;
            ram_rdata[OVR]   = ovr;
         end
      end
   end

   // Serializer state register, including the registered tx line.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state  <= IDLE;
         bcnt   <= '0;
         bitidx <= '0;
         shreg  <= 8'h00;
         tx     <= 1'b1;
      end else begin
         state  <= state_n;
         bcnt   <= bcnt_n;
         bitidx <= bitidx_n;
         shreg  <= shreg_n;
         tx     <= tx_d;
      end
   end

   // Next-state logic: bit timing, shifting, and FIFO pops at frame boundaries.
   always_comb begin
      state_n  = state;
      bcnt_n   = bcnt;
      bitidx_n = bitidx;
      shreg_n  = shreg;
      fifo_pop = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shreg_n  = fifo_dout;
               bcnt_n   = '0;
               state_n  = START;
            end
         end
         START: begin
            if (bit_end) begin
               bcnt_n   = '0;
               bitidx_n = 3'd0;
               state_n  = DATA;
            end else begin
               bcnt_n = bcnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               bcnt_n   = '0;
               shreg_n  = {1'b0, shreg[7:1]};
               bitidx_n = bitidx + 3'd1;
               if (bitidx == 3'd7) state_n = STOP;
            end else begin
               bcnt_n = bcnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               bcnt_n = '0;
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shreg_n  = fifo_dout;
                  state_n  = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               bcnt_n = bcnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs: line level for the upcoming state, status and interrupt.
   always_comb begin
      case (state_n)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_n[0];
         default: tx_d = 1'b1;
      endcase
      busy   = (state != IDLE) | ~fifo_empty;
      tx_irq = ie & ready;
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

   localparam logic [31:0] CTRL_A = 32'hFFFF_0008;
   localparam logic [31:0] DATA_A = 32'hFFFF_000C;

   logic        clk_in;
   logic        reset;
   logic        ram_ena;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        sel;
   logic        tx;
   logic        busy;
   logic        tx_irq;

   int n_vec = 0;
   int n_err = 0;

   mmio_uart_tx #(
      .CLK_DIV    (4),
      .FIFO_DEPTH (4),
      .ADDR_BASE  (32'hFFFF_0008)
   ) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .ram_ena   (ram_ena),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .sel       (sel),
      .tx        (tx),
      .busy      (busy),
      .tx_irq    (tx_irq)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Expected line level for bit slot i (0 = start, 1..8 = data LSB first, 9 = stop).
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0)      return 1'b0;
      else if (i == 9) return 1'b1;
      else             return b[i-1];
   endfunction

   task automatic do_reset();
      reset    = 1'b1;
      ram_ena  = 1'b0;
      ram_addr = 32'h0;
      ram_wdata = 32'h0;
      repeat (2) @(posedge clk_in);
      #1;
      reset = 1'b0;
   endtask

   // Store takes effect on the next rising edge; returns 1 time unit after it.
   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
      ram_addr  = a;
      ram_wdata = d;
      ram_ena   = 1'b1;
      @(posedge clk_in);
      #1;
      ram_ena   = 1'b0;
      ram_addr  = 32'h0;
      ram_wdata = 32'h0;
   endtask

   task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output logic s);
      ram_ena  = 1'b0;
      ram_addr = a;
      #1;
      d = ram_rdata;
      s = sel;
      ram_addr = 32'h0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        s;
      do_reset();
      cpu_read(CTRL_A, rd, s);
      n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL reset_ctrl: got %h want %h", rd, 32'h1); end
      n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL reset_sel_ctrl: got %b want 1", s); end
      n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (tx_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", tx_irq); end
      cpu_read(32'h1001_0000, rd, s);
      n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL dmem_sel: got %b want 0", s); end
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL dmem_rdata: got %h want 0", rd); end
      cpu_read(DATA_A, rd, s);
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", rd); end
      cpu_read(32'hFFFF_0010, rd, s);
      n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL above_sel: got %b want 0", s); end
      cpu_read(32'hFFFF_000B, rd, s);
      n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL ctrl_alias: got %h want %h", rd, 32'h1); end
      // A store just outside the window must not queue anything.
      cpu_write(32'hFFFF_0010, 32'h99);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stray_write_busy: got %b want 0", busy); end
      cpu_read(DATA_A, rd, s);
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL stray_write_data: got %h want 0", rd); end
   endtask

   task automatic test_single_frame();
      logic [9:0]  pat;
      logic [31:0] rd;
      logic        s;
      pat = 10'b10_1000_0010;   // 0x41 frame, slot 0 in bit 0
      cpu_write(DATA_A, 32'h41);
      n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL frame_pre_tx: got %b want 1", tx); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL frame_busy: got %b want 1", busy); end
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < 4; c++) begin
            @(posedge clk_in); #1;
            n_vec++;
            if (tx !== pat[b]) begin
               n_err++; $display("FAIL frame41 bit%0d cyc%0d: got %b want %b", b, c, tx, pat[b]);
            end
         end
      end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL frame_busy_stop: got %b want 1", busy); end
      @(posedge clk_in); #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL frame_busy_end: got %b want 0", busy); end
      n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL frame_idle_tx: got %b want 1", tx); end
      cpu_read(32'hFFFF_000F, rd, s);
      n_vec++; if (rd !== 32'h41) begin n_err++; $display("FAIL data_readback: got %h want %h", rd, 32'h41); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        s;
      logic [7:0]  byt;
      logic        exp;
      cpu_write(DATA_A, 32'h55);
      cpu_write(DATA_A, 32'hAA);
      // First start bit was launched on the second store's edge; k counts cycles from there.
      for (int k = 0; k < 80; k++) begin
         if (k > 0) begin @(posedge clk_in); #1; end
         byt = (k < 40) ? 8'h55 : 8'hAA;
         exp = frame_bit(byt, (k % 40) / 4);
         n_vec++;
         if (tx !== exp) begin
            n_err++; $display("FAIL b2b cyc%0d: got %b want %b", k, tx, exp);
         end
      end
      @(posedge clk_in); #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
      cpu_read(DATA_A, rd, s);
      n_vec++; if (rd !== 32'hAA) begin n_err++; $display("FAIL b2b_last: got %h want %h", rd, 32'hAA); end
   endtask

   task automatic test_irq_overflow();
      logic [31:0] rd;
      logic        s;
      int          n;
      do_reset();
      cpu_write(CTRL_A, 32'h2);
      n_vec++; if (tx_irq !== 1'b1) begin n_err++; $display("FAIL irq_empty: got %b want 1", tx_irq); end
      cpu_read(CTRL_A, rd, s);
      n_vec++; if (rd !== 32'h3) begin n_err++; $display("FAIL irq_ctrl: got %h want %h", rd, 32'h3); end
      for (int i = 1; i <= 6; i++) cpu_write(DATA_A, i);
      n_vec++; if (tx_irq !== 1'b0) begin n_err++; $display("FAIL irq_full: got %b want 0", tx_irq); end
      cpu_read(CTRL_A, rd, s);
      n_vec++; if (rd !== 32'h6) begin n_err++; $display("FAIL ovr_ctrl: got %h want %h", rd, 32'h6); end
      cpu_read(DATA_A, rd, s);
      n_vec++; if (rd !== 32'h5) begin n_err++; $display("FAIL ovr_last: got %h want %h", rd, 32'h5); end
      cpu_write(CTRL_A, 32'h6);
      cpu_read(CTRL_A, rd, s);
      n_vec++; if (rd !== 32'h2) begin n_err++; $display("FAIL ovr_clear: got %h want %h", rd, 32'h2); end
      // First frame ends 41 edges after the first store; the CTRL store used edge 6.
      n = 0;
      while (tx_irq !== 1'b1 && n < 200) begin
         @(posedge clk_in); #1;
         n++;
      end
      n_vec++; if (n !== 35) begin n_err++; $display("FAIL irq_after_pop cycles: got %0d want 35", n); end
      cpu_read(CTRL_A, rd, s);
      n_vec++; if (rd !== 32'h3) begin n_err++; $display("FAIL ctrl_after_pop: got %h want %h", rd, 32'h3); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] rd;
      logic        s;
      int          bad;
      do_reset();
      cpu_write(DATA_A, 32'h00);
      cpu_write(DATA_A, 32'h33);
      repeat (17) @(posedge clk_in);
      #1;
      n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL mid_bit3_tx: got %b want 0", tx); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
      // Reset together with a competing store; reset must win.
      reset     = 1'b1;
      ram_ena   = 1'b1;
      ram_addr  = DATA_A;
      ram_wdata = 32'h77;
      @(posedge clk_in); #1;
      n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL abort_tx: got %b want 1", tx); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
      reset     = 1'b0;
      ram_ena   = 1'b0;
      ram_addr  = 32'h0;
      ram_wdata = 32'h0;
      cpu_read(CTRL_A, rd, s);
      n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL abort_ctrl: got %h want %h", rd, 32'h1); end
      cpu_read(DATA_A, rd, s);
      n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL abort_data: got %h want 0", rd); end
      bad = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk_in); #1;
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
   endtask

   initial begin
      reset     = 1'b1;
      ram_ena   = 1'b0;
      ram_addr  = 32'h0;
      ram_wdata = 32'h0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_irq_overflow();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
